// File: rtl/fifob_pkg.sv
// Shared constants and types for the result read-back buffer.
package fifob_pkg;

  localparam int RDBUF_DATA_W     = 32;
  localparam int RDBUF_DEPTH_LOG2 = 10;

  typedef logic [RDBUF_DEPTH_LOG2:0]   rdbuf_count_t;
  typedef logic [RDBUF_DEPTH_LOG2-1:0] rdbuf_ptr_t;

  function automatic int rdbuf_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/fifob_rdbuf_if.sv
// Bus between the result producer / host read side and the read-back buffer.
interface fifob_rdbuf_if
  import fifob_pkg::*;
#(
  parameter int DATA_W     = RDBUF_DATA_W,
  parameter int DEPTH_LOG2 = RDBUF_DEPTH_LOG2
);

  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                full;
  logic                rd_en;
  logic [DATA_W-1:0]   rd_data;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                flush;
  logic                almost_full;

  modport master (
    output wr_data, wr_en, rd_en, flush,
    input  full, rd_data, empty, count, overflow, almost_full
  );

  modport slave (
    input  wr_data, wr_en, rd_en, flush,
    output full, rd_data, empty, count, overflow, almost_full
  );

endinterface

// File: rtl/fifob_rdbuf_ram.sv
// Simple dual-port storage with a registered, read-first output stage (block RAM friendly).
module fifob_rdbuf_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Simultaneous read and write of one address returns the old word.
  always_ff @(posedge CLK) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifob_rdbuf.sv
// Result read-back buffer: pointers, explicit occupancy count, flags and sticky overflow.
// Optional almost_full comparator is built only when FIFOB_RDBUF_ALMOST_FULL_EN is defined.
module fifob_rdbuf
  import fifob_pkg::*;
#(
  parameter int DATA_W     = RDBUF_DATA_W,
  parameter int DEPTH_LOG2 = RDBUF_DEPTH_LOG2,
  parameter int AF_MARGIN  = 16
) (
  input  logic          CLK,
  input  logic          rst_n,
  fifob_rdbuf_if.slave  bus
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_MAX = DEPTH[DEPTH_LOG2:0];

  if (AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_bad_margin
    $error("fifob_rdbuf: AF_MARGIN out of range");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  ovf_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;

  // flush suppresses both strobes so nothing moves in the flush cycle.
  assign rd_acc  = bus.rd_en & ~empty_q & ~bus.flush;
  assign wr_acc  = bus.wr_en & (~full_q | rd_acc) & ~bus.flush;
  assign wr_drop = bus.wr_en & full_q & ~rd_acc & ~bus.flush;

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc)      count_nxt = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_nxt = count_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_MAX);
      empty_q <= (count_nxt == '0);
      ovf_q   <= ovf_q | wr_drop;
    end
  end

  fifob_rdbuf_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .CLK   (CLK),
    .rst_n (rst_n),
    .we    (wr_acc & rst_n),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

`ifdef FIFOB_RDBUF_ALMOST_FULL_EN
  localparam logic [DEPTH_LOG2:0] AF_THRESH = CNT_MAX - AF_MARGIN[DEPTH_LOG2:0];

  logic af_q;

  always_ff @(posedge CLK) begin
    if (!rst_n || bus.flush) af_q <= 1'b0;
    else                     af_q <= (count_nxt >= AF_THRESH);
  end

  assign bus.almost_full = af_q;
`else
  assign bus.almost_full = 1'b0;
`endif

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_fifob_rdbuf.sv
// Self-checking bench for fifob_rdbuf against a queue-based reference model.
module tb_fifob_rdbuf;

  localparam int DEPTH     = 1024;
  localparam int AF_MARGIN = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifob_rdbuf_if #(.DATA_W(32), .DEPTH_LOG2(10)) bus ();

  fifob_rdbuf #(.DATA_W(32), .DEPTH_LOG2(10), .AF_MARGIN(AF_MARGIN)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  logic        m_ovf;
  logic [31:0] m_rd;

  function automatic logic exp_af();
`ifdef FIFOB_RDBUF_ALMOST_FULL_EN
    return (q.size() >= DEPTH - AF_MARGIN);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, update the model at the edge, return at the falling edge.
  task automatic cycle(input logic rst, input logic we, input logic [31:0] wd,
                       input logic re, input logic fl);
    bit do_rd;
    bit do_wr;
    rst_n       = rst;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.flush   = fl;
    @(posedge clk);
    if (!rst) begin
      q.delete(); m_ovf = 1'b0; m_rd = '0;
    end else if (fl) begin
      q.delete(); m_ovf = 1'b0;
    end else begin
      do_rd = re && (q.size() > 0);
      do_wr = we && ((q.size() < DEPTH) || do_rd);
      if (do_rd) m_rd = q.pop_front();
      if (do_wr) q.push_back(wd);
      else if (we) m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    checks++; if (bus.count !== 11'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    checks++; if (bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
  endtask

  task automatic test_basic();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    checks++; if (bus.count !== 11'd4) begin failures++; $display("FAIL basic_count4 got=%0d exp=4", bus.count); end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.rd_data !== 32'(i)) begin failures++; $display("FAIL basic_rd got=%h exp=%h", bus.rd_data, 32'(i)); end
      checks++; if (bus.count !== 11'(4 - i)) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", bus.count, 4 - i); end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_fill_overflow();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      checks++; if (bus.almost_full !== exp_af()) begin failures++; $display("FAIL fill_af cnt=%0d got=%b exp=%b", i + 1, bus.almost_full, exp_af()); end
    end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    checks++; if (bus.count !== 11'd1024) begin failures++; $display("FAIL fill_count got=%0d exp=1024", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_pre got=%b exp=0", bus.overflow); end
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", bus.overflow); end
    checks++; if (bus.count !== 11'd1024) begin failures++; $display("FAIL fill_count_drop got=%0d exp=1024", bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.rd_data !== 32'hA000_0000 + 32'(i)) begin failures++; $display("FAIL drain_rd i=%0d got=%h exp=%h", i, bus.rd_data, 32'hA000_0000 + 32'(i)); end
      checks++; if (bus.almost_full !== exp_af()) begin failures++; $display("FAIL drain_af cnt=%0d got=%b exp=%b", DEPTH - 1 - i, bus.almost_full, exp_af()); end
    end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_flush got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_full_rw();
    logic [31:0] first;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    first = q[0];
    cycle(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    checks++; if (bus.count !== 11'd1024) begin failures++; $display("FAIL fullrw_count got=%0d exp=1024", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fullrw_ovf got=%b exp=0", bus.overflow); end
    checks++; if (bus.rd_data !== first) begin failures++; $display("FAIL fullrw_rd got=%h exp=%h", bus.rd_data, first); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.rd_data !== m_rd) begin failures++; $display("FAIL fullrw_drain i=%0d got=%h exp=%h", i, bus.rd_data, m_rd); end
    end
    checks++; if (bus.rd_data !== 32'h1234_5678) begin failures++; $display("FAIL fullrw_last got=%h exp=12345678", bus.rd_data); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL fullrw_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_empty_rw();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h99, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.rd_data !== 32'h99) begin failures++; $display("FAIL emptyrw_pre got=%h exp=99", bus.rd_data); end
    cycle(1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
    checks++; if (bus.count !== 11'd1) begin failures++; $display("FAIL emptyrw_count got=%0d exp=1", bus.count); end
    checks++; if (bus.rd_data !== 32'h99) begin failures++; $display("FAIL emptyrw_hold got=%h exp=99", bus.rd_data); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL emptyrw_empty got=%b exp=0", bus.empty); end
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.rd_data !== 32'h55) begin failures++; $display("FAIL emptyrw_rd got=%h exp=55", bus.rd_data); end
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.rd_data !== 32'h55) begin failures++; $display("FAIL emptyrd_hold got=%h exp=55", bus.rd_data); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL emptyrd_ovf got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_flush_reset();
    logic [31:0] held;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 700; i++) cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    held = m_rd;
    cycle(1'b1, 1'b1, 32'hFACE, 1'b1, 1'b1);
    checks++; if (bus.count !== 11'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%b exp=0", bus.overflow); end
    checks++; if (bus.rd_data !== held) begin failures++; $display("FAIL flush_hold got=%h exp=%h", bus.rd_data, held); end
    cycle(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.rd_data !== 32'h77) begin failures++; $display("FAIL flush_rd got=%h exp=77", bus.rd_data); end
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, $urandom, 1'b1, 1'b0);
    checks++; if (bus.count !== 11'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL rst_mid_rd got=%h exp=0", bus.rd_data); end
    cycle(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.rd_data !== 32'h77) begin failures++; $display("FAIL rst_mid_rd77 got=%h exp=77", bus.rd_data); end
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      cycle(1'b1, ($urandom_range(99) < 70), $urandom, ($urandom_range(99) < 45),
            ($urandom_range(1499) == 0));
      checks++; if (bus.count !== 11'(q.size())) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, bus.count, q.size()); end
      checks++; if (bus.empty !== (q.size() == 0)) begin failures++; $display("FAIL rand_empty n=%0d got=%b", n, bus.empty); end
      checks++; if (bus.full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rand_full n=%0d got=%b", n, bus.full); end
      checks++; if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rand_ovf n=%0d got=%b exp=%b", n, bus.overflow, m_ovf); end
      checks++; if (bus.rd_data !== m_rd) begin failures++; $display("FAIL rand_rd n=%0d got=%h exp=%h", n, bus.rd_data, m_rd); end
      checks++; if (bus.almost_full !== exp_af()) begin failures++; $display("FAIL rand_af n=%0d got=%b exp=%b", n, bus.almost_full, exp_af()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifob_rdbuf.md
Name: fifob_rdbuf

Overview:
- Result buffer directly downstream of the chip-interface top level.
- Consumes the 32-bit result words and write strobe that the interface top level emits after I2C/SPI reads.
- Buffers up to 2^DEPTH_LOG2 words for host pipe-out readback.
- Exposes an occupancy count and a sticky overflow flag for host polling via WireOut.

Parameters:
- DATA_W, 32, word width; must match the result bus.
- DEPTH_LOG2, 10, log2 of buffer depth (1024 words).
- AF_MARGIN, 16, free-slot margin for almost_full (optional feature only).

Ports:
- CLK  in  1  process clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_data  in  DATA_W  result word (driven from FIFOB_IN).
- wr_en  in  1  write strobe (driven from FIFOB_wen).
- full  out  1  buffer holds 2^DEPTH_LOG2 words.
- rd_en  in  1  host pipe-out read strobe.
- rd_data  out  DATA_W  read word, valid one cycle after an accepted rd_en.
- empty  out  1  buffer holds 0 words.
- count  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- flush  in  1  synchronous clear of contents and overflow.
- almost_full  out  1  count >= 2^DEPTH_LOG2 - AF_MARGIN (optional feature).

Behaviour:
- Reset (rst_n=0 at a clock edge) sets:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, overflow=0, rd_data=0, almost_full=0.
  - Reset is allowed mid-operation: any in-flight read is abandoned and contents are discarded.
- Pointers are DEPTH_LOG2 bits wide and wrap from 2^DEPTH_LOG2-1 to 0.
  - count is maintained explicitly; it is not derived from the pointers.
- Read acceptance: rd_acc = rd_en & ~empty.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
  - When full and a read happens in the same cycle, the write is accepted and count stays at max.
- Empty with rd_en & wr_en in the same cycle: the read is ignored, the write is accepted, count becomes 1. There is no same-cycle bypass.
- Read latency is 1 cycle. rd_data is registered and updates on the edge after rd_acc; otherwise it holds its last value.
- Read on empty: no pointer change, rd_data holds, overflow is unaffected.
- Write on full without a same-cycle read: the word is dropped, pointers do not move, and overflow is set to 1.
  - overflow stays 1 until flush or reset.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - unchanged when both or neither occur.
- full, empty and almost_full are registered and consistent with count on the same cycle.
- flush=1 at a clock edge: same effect as reset on pointers, count, flags and overflow. rd_data holds. Any wr_en/rd_en in that cycle is ignored.
  - flush has lower priority than rst_n.
- No internal state machine is required beyond pointer/count bookkeeping. The storage read port is one registered stage, so it maps to block RAM.

Optional Feature:
- Macro: FIFOB_RDBUF_ALMOST_FULL_EN.
- Defined: almost_full is registered and asserts when next-count >= 2^DEPTH_LOG2 - AF_MARGIN.
  - It deasserts when the count falls below the threshold.
  - It clears on reset and on flush.
- Undefined: almost_full is tied to constant 0 and no comparator is built. All other behaviour is identical.

Decomposition:
- Shared package fifob_pkg holds:
  - RDBUF_DATA_W=32 and RDBUF_DEPTH_LOG2=10 default constants.
  - A count type of RDBUF_DEPTH_LOG2+1 bits.
  - A pointer type of RDBUF_DEPTH_LOG2 bits.
- Sub-module fifob_rdbuf_ram: simple dual-port RAM with one write port, one read port and a registered read output. It contains no flags or counters.
- fifob_rdbuf owns pointers, count, flags and the acceptance logic.

Test Plan:
- Reset, then write 0x00000001..0x00000004 on 4 consecutive cycles, then read 4 -> rd_data = 1,2,3,4, each one cycle after its rd_en; count 4->0; empty=1 at end.
- Write 1024 words 0xA0000000+i -> full=1, count=1024. A 1025th write of 0xDEADBEEF is dropped and overflow=1. Reading all words returns 0xA0000000..0xA00003FF with no 0xDEADBEEF.
- At full, rd_en and wr_en=0x12345678 in the same cycle -> count stays 1024, overflow stays 0, and 0x12345678 is read last after a full drain.
- From empty, rd_en and wr_en=0x55 together -> no read occurs, count=1, rd_data unchanged; the next rd_en returns 0x55.
- Fill 700 words, assert flush -> count=0, empty=1, overflow=0. Then write 0x77 and read -> 0x77. Repeat with rst_n=0 mid-write burst -> same clean state.
- Macro FIFOB_RDBUF_ALMOST_FULL_EN defined with AF_MARGIN=16 -> almost_full rises when count reaches 1008 and falls at 1007. Macro undefined -> almost_full is 0 throughout.
